// File: rtl/alarm_controller_nz_pkg.sv
// alarm_pkg: shared state codes and programming-select codes for the
// multi-door anti-theft controller (alarm_controller_nz) and its bench.
//   main_state_t : main FSM state, driven out on the 3-bit state port
//   arm_state_t  : passive-arm sub-FSM state, active only in DISARMED
//   PSEL_*       : prog_sel codes selecting which delay register is written
package alarm_pkg;

    typedef enum logic [2:0] {
        ARMED      = 3'd0,
        TRIGGER    = 3'd1,
        ALARM_ON   = 3'd2,
        ALARM_HOLD = 3'd3,
        DISARMED   = 3'd4
    } main_state_t;

    typedef enum logic [1:0] {
        WAIT_IGN_OFF    = 2'd0,
        WAIT_DRV_OPEN   = 2'd1,
        WAIT_ALL_CLOSED = 2'd2,
        ARM_DELAY       = 2'd3
    } arm_state_t;

    localparam logic [1:0] PSEL_ARM  = 2'd0;
    localparam logic [1:0] PSEL_DRV  = 2'd1;
    localparam logic [1:0] PSEL_PASS = 2'd2;
    localparam logic [1:0] PSEL_ON   = 2'd3;

endpackage

// File: rtl/alarm_controller_nz_countdown_timer.sv
// countdown_timer: seconds countdown with its own tick prescaler.
//   clock, reset : system clock, asynchronous active-high reset
//   load, value  : load countdown with value (0 is clamped to 1), restart prescaler
//   cancel       : clear the countdown (prescaler keeps running)
//   tick         : 1-cycle pulse every TICK_CYCLES clocks (free running)
//   count        : seconds remaining, 0 when idle
//   expired      : 1-cycle pulse in the cycle count goes 1 -> 0
module countdown_timer #(
    parameter int unsigned TIME_W      = 4,
    parameter int unsigned TICK_CYCLES = 100000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              cancel,
    input  logic [TIME_W-1:0] value,
    output logic              tick,
    output logic [TIME_W-1:0] count,
    output logic              expired
);

    localparam int unsigned PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [PRE_W-1:0] pre;

    assign tick = (pre == PRE_W'(TICK_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pre <= '0;
        else if (load || tick)
            pre <= '0;
        else
            pre <= pre + 1'b1;
    end

    // Load beats a coincident tick; cancel beats a decrement.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= (value == '0) ? TIME_W'(1) : value;
        else if (cancel)
            count <= '0;
        else if (tick && count != '0)
            count <= count - 1'b1;
    end

    assign expired = tick && !load && !cancel && (count == TIME_W'(1));

endmodule

// File: rtl/alarm_controller_nz.sv
// alarm_controller_nz: multi-door vehicle anti-theft controller with passive
// arming, programmable delays and a latched trigger-door record.
//   clock, reset          : system clock, asynchronous active-high reset
//   ignition              : 1 = ignition on
//   doors[NUM_DOORS]      : 1 = door open (debounced upstream)
//   prog_sel/value/we     : delay register write port (PSEL_* codes)
//   state                 : main FSM state code
//   status                : status LED
//   siren_en              : siren generator enable
//   countdown             : seconds left on the active timer, 0 when idle
//   trig_door             : doors that caused / joined the current trigger
module alarm_controller_nz
    import alarm_pkg::*;
#(
    parameter int unsigned NUM_DOORS   = 4,
    parameter int unsigned DRIVER_IDX  = 0,
    parameter int unsigned TIME_W      = 4,
    parameter int unsigned TICK_CYCLES = 100000000,
    parameter int unsigned T_ARM_DEF   = 6,
    parameter int unsigned T_DRV_DEF   = 8,
    parameter int unsigned T_PASS_DEF  = 15,
    parameter int unsigned T_ON_DEF    = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ignition,
    input  logic [NUM_DOORS-1:0] doors,
    input  logic [1:0]           prog_sel,
    input  logic [TIME_W-1:0]    prog_value,
    input  logic                 prog_we,
    output logic [2:0]           state,
    output logic                 status,
    output logic                 siren_en,
    output logic [TIME_W-1:0]    countdown,
    output logic [NUM_DOORS-1:0] trig_door
);

    main_state_t state_q, state_d;
    arm_state_t  arm_q, arm_d;
    logic [NUM_DOORS-1:0] trig_q, trig_d;
    logic [TIME_W-1:0]    t_arm, t_drv, t_pass, t_on;
    logic                 tgl_q;

    logic              tmr_load, tmr_cancel, tick, expired;
    logic [TIME_W-1:0] tmr_value;

    wire any_open = |doors;

    countdown_timer #(
        .TIME_W      (TIME_W),
        .TICK_CYCLES (TICK_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (tmr_load),
        .cancel  (tmr_cancel),
        .value   (tmr_value),
        .tick    (tick),
        .count   (countdown),
        .expired (expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            t_arm  <= TIME_W'(T_ARM_DEF);
            t_drv  <= TIME_W'(T_DRV_DEF);
            t_pass <= TIME_W'(T_PASS_DEF);
            t_on   <= TIME_W'(T_ON_DEF);
        end else if (prog_we) begin
            case (prog_sel)
                PSEL_ARM:  t_arm  <= prog_value;
                PSEL_DRV:  t_drv  <= prog_value;
                PSEL_PASS: t_pass <= prog_value;
                default:   t_on   <= prog_value;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ARMED;
            arm_q   <= WAIT_IGN_OFF;
            trig_q  <= '0;
            tgl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            trig_q  <= trig_d;
            if (state_q != ARMED)
                tgl_q <= 1'b0;
            else if (tick)
                tgl_q <= ~tgl_q;
        end
    end

    // prog_we and ignition are pre-empting events handled ahead of the
    // per-state case; every exit from a timed state cancels its timer so
    // countdown reads 0 whenever nothing is being timed.
    always_comb begin
        state_d    = state_q;
        arm_d      = arm_q;
        trig_d     = trig_q;
        tmr_load   = 1'b0;
        tmr_cancel = 1'b0;
        tmr_value  = t_arm;
        if (prog_we) begin
            state_d    = ARMED;
            tmr_cancel = 1'b1;
        end else if (state_q != DISARMED && ignition) begin
            state_d    = DISARMED;
            arm_d      = WAIT_IGN_OFF;
            tmr_cancel = 1'b1;
        end else begin
            case (state_q)
                ARMED: if (any_open) begin
                    state_d   = TRIGGER;
                    tmr_load  = 1'b1;
                    tmr_value = doors[DRIVER_IDX] ? t_drv : t_pass;
                    trig_d    = doors;
                end
                TRIGGER: begin
                    trig_d = trig_q | doors;
                    if (expired)
                        state_d = ALARM_ON;
                end
                ALARM_ON: if (!any_open) begin
                    state_d   = ALARM_HOLD;
                    tmr_load  = 1'b1;
                    tmr_value = t_on;
                end
                ALARM_HOLD: begin
                    if (any_open) begin
                        state_d    = ALARM_ON;
                        tmr_cancel = 1'b1;
                    end else if (expired) begin
                        state_d = ARMED;
                        trig_d  = '0;
                    end
                end
                DISARMED: begin
                    case (arm_q)
                        WAIT_IGN_OFF: if (!ignition) arm_d = WAIT_DRV_OPEN;
                        WAIT_DRV_OPEN: begin
                            if (ignition)
                                arm_d = WAIT_IGN_OFF;
                            else if (doors[DRIVER_IDX])
                                arm_d = WAIT_ALL_CLOSED;
                        end
                        WAIT_ALL_CLOSED: if (!any_open) begin
                            arm_d     = ARM_DELAY;
                            tmr_load  = 1'b1;
                            tmr_value = t_arm;
                        end
                        ARM_DELAY: begin
                            if (any_open) begin
                                arm_d      = WAIT_ALL_CLOSED;
                                tmr_cancel = 1'b1;
                            end else if (ignition) begin
                                arm_d      = WAIT_IGN_OFF;
                                tmr_cancel = 1'b1;
                            end else if (expired) begin
                                state_d = ARMED;
                            end
                        end
                        default: arm_d = WAIT_IGN_OFF;
                    endcase
                end
                default: state_d = ARMED;
            endcase
        end
    end

    always_comb begin
        status   = 1'b0;
        siren_en = 1'b0;
        case (state_q)
            ARMED:                status = tgl_q;
            TRIGGER:              status = 1'b1;
            ALARM_ON, ALARM_HOLD: begin
                status   = 1'b1;
                siren_en = 1'b1;
            end
            default:              status = 1'b0;
        endcase
    end

    assign state     = state_q;
    assign trig_door = trig_q;

endmodule

// File: tb/tb_alarm_controller_nz.sv
// Testbench for alarm_controller_nz (TICK_CYCLES = 10, default delays).
// Each scenario task pushes the expected output snapshot onto a scoreboard
// queue as it drives stimulus, then pops and compares once the DUT has
// clocked. Snapshot = {state, status, siren_en, countdown, trig_door}.
module tb_alarm_controller_nz;
    import alarm_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       ignition;
    logic [3:0] doors;
    logic [1:0] prog_sel;
    logic [3:0] prog_value;
    logic       prog_we;
    logic [2:0] state;
    logic       status;
    logic       siren_en;
    logic [3:0] countdown;
    logic [3:0] trig_door;

    alarm_controller_nz #(
        .TICK_CYCLES (10)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ignition   (ignition),
        .doors      (doors),
        .prog_sel   (prog_sel),
        .prog_value (prog_value),
        .prog_we    (prog_we),
        .state      (state),
        .status     (status),
        .siren_en   (siren_en),
        .countdown  (countdown),
        .trig_door  (trig_door)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [12:0] v;
        logic [12:0] m;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [12:0] FULL   = 13'h1FFF;
    localparam logic [12:0] NOST   = 13'h1DFF;  // ignore status (ARMED blink phase)
    localparam logic [12:0] NOTR   = 13'h1FF0;  // ignore trig_door
    localparam logic [12:0] NOSTTR = 13'h1DF0;

    wire [12:0] obs = {state, status, siren_en, countdown, trig_door};

    function automatic logic [12:0] mk(input logic [2:0] s, input logic st,
                                       input logic sr, input logic [3:0] cd,
                                       input logic [3:0] tr);
        return {s, st, sr, cd, tr};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(2);
        sb.push_back('{"reset_outputs", mk(ARMED, 0, 0, 0, 0), FULL});
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        reset = 1'b0;
        sb.push_back('{"armed_status_before_tick", mk(ARMED, 0, 0, 0, 0), FULL});
        step(9);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        sb.push_back('{"armed_status_toggle", mk(ARMED, 1, 0, 0, 0), FULL});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
    endtask

    task automatic test_trigger_pass;
        doors = 4'b0100;
        sb.push_back('{"pass_trigger", mk(TRIGGER, 1, 0, 15, 4'b0100), FULL});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        doors = 4'b0010;
        sb.push_back('{"trig_or_door1", mk(TRIGGER, 1, 0, 15, 4'b0110), FULL});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        doors = 4'b0000;
        sb.push_back('{"pass_last_second", mk(TRIGGER, 1, 0, 1, 4'b0110), FULL});
        step(148);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        sb.push_back('{"alarm_on_at_150", mk(ALARM_ON, 1, 1, 0, 4'b0110), FULL});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
    endtask

    task automatic test_alarm_hold;
        sb.push_back('{"hold_load", mk(ALARM_HOLD, 1, 1, 10, 4'b0110), FULL});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        sb.push_back('{"hold_5s_left", mk(ALARM_HOLD, 1, 1, 5, 4'b0110), FULL});
        step(50);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        doors = 4'b0010;
        sb.push_back('{"hold_reopen_on", mk(ALARM_ON, 1, 1, 0, 4'b0110), FULL});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        doors = 4'b0000;
        sb.push_back('{"hold_reload", mk(ALARM_HOLD, 1, 1, 10, 4'b0110), FULL});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        sb.push_back('{"hold_last_second", mk(ALARM_HOLD, 1, 1, 1, 4'b0110), FULL});
        step(99);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        sb.push_back('{"hold_to_armed", mk(ARMED, 0, 0, 0, 4'b0000), NOST});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
    endtask

    task automatic test_trigger_driver;
        doors = 4'b1001;
        sb.push_back('{"driver_wins", mk(TRIGGER, 1, 0, 8, 4'b1001), FULL});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        ignition = 1'b1;
        doors    = 4'b0000;
        sb.push_back('{"ign_disarm", mk(DISARMED, 0, 0, 0, 0), NOTR});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
    endtask

    task automatic test_passive_arm;
        ignition = 1'b0;
        step(1);
        doors = 4'b0001;
        step(1);
        doors = 4'b0000;
        sb.push_back('{"arm_delay_load", mk(DISARMED, 0, 0, 6, 0), NOTR});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        sb.push_back('{"arm_delay_3s", mk(DISARMED, 0, 0, 3, 0), NOTR});
        step(30);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        doors = 4'b1000;
        sb.push_back('{"arm_delay_abort", mk(DISARMED, 0, 0, 0, 0), NOTR});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        doors = 4'b0000;
        sb.push_back('{"arm_delay_restart", mk(DISARMED, 0, 0, 6, 0), NOTR});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        sb.push_back('{"arm_delay_last", mk(DISARMED, 0, 0, 1, 0), NOTR});
        step(59);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        sb.push_back('{"passive_armed", mk(ARMED, 0, 0, 0, 0), NOSTTR});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
    endtask

    task automatic test_prog_clamp;
        doors = 4'b0100;
        sb.push_back('{"prog_pre_trigger", mk(TRIGGER, 1, 0, 15, 4'b0100), FULL});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        doors      = 4'b0000;
        prog_we    = 1'b1;
        prog_sel   = PSEL_PASS;
        prog_value = 4'd0;
        sb.push_back('{"prog_to_armed", mk(ARMED, 0, 0, 0, 0), NOSTTR});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        prog_we = 1'b0;
        doors   = 4'b0100;
        sb.push_back('{"clamp_load_1", mk(TRIGGER, 1, 0, 1, 4'b0100), FULL});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        doors = 4'b0000;
        sb.push_back('{"clamp_cycle9", mk(TRIGGER, 1, 0, 1, 4'b0100), FULL});
        step(9);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        sb.push_back('{"clamp_expire10", mk(ALARM_ON, 1, 1, 0, 4'b0100), FULL});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
    endtask

    task automatic test_reset_mid_hold;
        sb.push_back('{"hold_before_reset", mk(ALARM_HOLD, 1, 1, 10, 4'b0100), FULL});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        step(20);
        reset = 1'b1;
        sb.push_back('{"async_reset_hold", mk(ARMED, 0, 0, 0, 0), FULL});
        #1;
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        step(1);
        reset = 1'b0;
        doors = 4'b0100;
        sb.push_back('{"pass_default_restored", mk(TRIGGER, 1, 0, 15, 4'b0100), FULL});
        step(1);
        e = sb.pop_front(); n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs & e.m, e.v & e.m); end
        doors = 4'b0000;
    endtask

    initial begin
        reset      = 1'b1;
        ignition   = 1'b0;
        doors      = 4'b0000;
        prog_sel   = 2'd0;
        prog_value = 4'd0;
        prog_we    = 1'b0;
        test_reset;
        test_trigger_pass;
        test_alarm_hold;
        test_trigger_driver;
        test_passive_arm;
        test_prog_clamp;
        test_reset_mid_hold;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
